// File: rtl/alu_exec_unit.sv
// ---------------------------------------------------------------------------
// alu_exec_unit
//
// Execute-stage datapath for the single-cycle MIPS core. It combines the
// ALU-control decoder, the 32-bit ALU, the PC+4 adder and the branch-target
// adder. It also holds a small registered N/Z/V status-flag set that feeds the
// status-branch/jump logic. Everything is combinational except the three
// status flags.
//
// Ports:
//   clk_i            system clock; the flags update on its rising edge
//   rst_ni           asynchronous active-low reset; clears the flags only
//   aluop_i[1:0]     {aluop1,aluop0} from main control
//   funct_i[5:0]     instruction bits [5:0], decoded when aluop_i is 1x
//   a_i[W-1:0]       operand A (register read data 1)
//   b_i[W-1:0]       operand B (ALUSrc mux output)
//   pc_i[W-1:0]      current program counter
//   imm_sext_i[W-1:0] sign-extended 16-bit immediate
//   flag_we_i        capture the status flags at this clock edge
//   gout_o[2:0]      decoded ALU operation select
//   result_o[W-1:0]  ALU result
//   zero_o           high when result_o is all zeros
//   pc_plus4_o       pc_i + PC_INC
//   branch_target_o  pc_plus4_o + (imm_sext_i << 2)
//   flag_n_o         registered negative flag
//   flag_z_o         registered zero flag
//   flag_v_o         registered signed-overflow flag
// ---------------------------------------------------------------------------
module alu_exec_unit #(
    parameter int          WIDTH  = 32,
    parameter int unsigned PC_INC = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [1:0]       aluop_i,
    input  logic [5:0]       funct_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH-1:0] pc_i,
    input  logic [WIDTH-1:0] imm_sext_i,
    input  logic             flag_we_i,
    output logic [2:0]       gout_o,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o,
    output logic [WIDTH-1:0] pc_plus4_o,
    output logic [WIDTH-1:0] branch_target_o,
    output logic             flag_n_o,
    output logic             flag_z_o,
    output logic             flag_v_o
);

    // ALU operation encodings carried on gout_o
    localparam logic [2:0] GOUT_AND = 3'b000;
    localparam logic [2:0] GOUT_OR  = 3'b001;
    localparam logic [2:0] GOUT_ADD = 3'b010;
    localparam logic [2:0] GOUT_NOR = 3'b100;
    localparam logic [2:0] GOUT_SUB = 3'b110;
    localparam logic [2:0] GOUT_SLT = 3'b111;

    // R-type function codes
    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_NOR = 6'b100111;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    localparam logic [WIDTH-1:0] PcInc = WIDTH'(PC_INC);
    localparam logic [WIDTH-1:0] One   = WIDTH'(1);

    logic [2:0]       goutSel;
    logic [WIDTH-1:0] sumAdd;
    logic [WIDTH-1:0] diffSub;
    logic             ovfAdd;
    logic             ovfSub;
    logic             lessThan;
    logic [WIDTH-1:0] aluResult;
    logic             aluOverflow;
    logic             aluZero;

    logic flagN_q, flagN_d;
    logic flagZ_q, flagZ_d;
    logic flagV_q, flagV_d;

    // ALU-control decoder: loads/stores add, beq subtracts, R-type looks at
    // funct. Unknown funct codes fall back to add so the ALU never idles on
    // an undefined select.
    always_comb begin
        goutSel = GOUT_ADD;
        case (aluop_i)
            2'b00: goutSel = GOUT_ADD;
            2'b01: goutSel = GOUT_SUB;
            default: begin
                case (funct_i)
                    FUNCT_ADD: goutSel = GOUT_ADD;
                    FUNCT_SUB: goutSel = GOUT_SUB;
                    FUNCT_AND: goutSel = GOUT_AND;
                    FUNCT_OR:  goutSel = GOUT_OR;
                    FUNCT_NOR: goutSel = GOUT_NOR;
                    FUNCT_SLT: goutSel = GOUT_SLT;
                    default:   goutSel = GOUT_ADD;
                endcase
            end
        endcase
    end

    // Subtraction is done as a + ~b + 1 so it shares the adder form. The
    // signed less-than uses the difference sign corrected by the overflow
    // bit, which stays right even when a - b overflows.
    always_comb begin
        sumAdd   = a_i + b_i;
        diffSub  = a_i + ~b_i + One;
        ovfAdd   = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (sumAdd[WIDTH-1] != a_i[WIDTH-1]);
        ovfSub   = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (diffSub[WIDTH-1] != a_i[WIDTH-1]);
        lessThan = diffSub[WIDTH-1] ^ ovfSub;
    end

    // Result and overflow selection. The unused selects 011 and 101 give 0.
    always_comb begin
        aluResult   = '0;
        aluOverflow = 1'b0;
        case (goutSel)
            GOUT_ADD: begin
                aluResult   = sumAdd;
                aluOverflow = ovfAdd;
            end
            GOUT_SUB: begin
                aluResult   = diffSub;
                aluOverflow = ovfSub;
            end
            GOUT_AND: aluResult = a_i & b_i;
            GOUT_OR:  aluResult = a_i | b_i;
            GOUT_NOR: aluResult = ~(a_i | b_i);
            GOUT_SLT: aluResult = {{(WIDTH-1){1'b0}}, lessThan};
            default:  aluResult = '0;
        endcase
        aluZero = ~|aluResult;
    end

    // The status register captures the flags of whatever the ALU is computing
    // when flag_we_i is high.
    always_comb begin
        flagN_d = aluResult[WIDTH-1];
        flagZ_d = aluZero;
        flagV_d = aluOverflow;
    end

    // Reset clears the flags asynchronously and takes priority over
    // flag_we_i.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            flagN_q <= 1'b0;
            flagZ_q <= 1'b0;
            flagV_q <= 1'b0;
        end else if (flag_we_i) begin
            flagN_q <= flagN_d;
            flagZ_q <= flagZ_d;
            flagV_q <= flagV_d;
        end
    end

    // Both PC adders wrap silently modulo 2^WIDTH.
    assign pc_plus4_o      = pc_i + PcInc;
    assign branch_target_o = pc_plus4_o + (imm_sext_i << 2);

    assign gout_o   = goutSel;
    assign result_o = aluResult;
    assign zero_o   = aluZero;
    assign flag_n_o = flagN_q;
    assign flag_z_o = flagZ_q;
    assign flag_v_o = flagV_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// ---------------------------------------------------------------------------
// tb_alu_exec_unit
//
// Scoreboard testbench for alu_exec_unit. The stimulus process drives one
// operation per cycle just after the rising edge and pushes the expected
// combinational response into a queue. A monitor pops one entry at every
// falling edge and compares it with the DUT outputs, together with the
// status flags tracked by a behavioural flag model.
// ---------------------------------------------------------------------------
module tb_alu_exec_unit;

    typedef struct {
        logic [2:0]  gout;
        logic [31:0] result;
        logic        zero;
        logic        ovf;
        logic [31:0] pcPlus4;
        logic [31:0] branchTarget;
    } expT;

    logic        clk;
    logic        rstN;
    logic [1:0]  aluop;
    logic [5:0]  funct;
    logic [31:0] opA;
    logic [31:0] opB;
    logic [31:0] pc;
    logic [31:0] immSext;
    logic        flagWe;
    logic [2:0]  gout;
    logic [31:0] result;
    logic        zero;
    logic [31:0] pcPlus4;
    logic [31:0] branchTarget;
    logic        flagN;
    logic        flagZ;
    logic        flagV;

    int checks = 0;
    int errors = 0;

    expT expQ[$];

    logic modelN;
    logic modelZ;
    logic modelV;

    alu_exec_unit #(
        .WIDTH  (32),
        .PC_INC (4)
    ) dut (
        .clk_i           (clk),
        .rst_ni          (rstN),
        .aluop_i         (aluop),
        .funct_i         (funct),
        .a_i             (opA),
        .b_i             (opB),
        .pc_i            (pc),
        .imm_sext_i      (immSext),
        .flag_we_i       (flagWe),
        .gout_o          (gout),
        .result_o        (result),
        .zero_o          (zero),
        .pc_plus4_o      (pcPlus4),
        .branch_target_o (branchTarget),
        .flag_n_o        (flagN),
        .flag_z_o        (flagZ),
        .flag_v_o        (flagV)
    );

    // 10 time-unit clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: the operation table applied with plain signed and
    // unsigned arithmetic, overflow judged by range on 64-bit values.
    function automatic expT modelCompute(input logic [1:0] op, input logic [5:0] fn,
                                         input logic [31:0] x, input logic [31:0] y,
                                         input logic [31:0] pcv, input logic [31:0] imm);
        expT    e;
        longint sx;
        longint sy;
        longint wide;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        e.gout = 3'b010;
        if (op == 2'b01) e.gout = 3'b110;
        else if (op[1]) begin
            if      (fn == 6'b100000) e.gout = 3'b010;
            else if (fn == 6'b100010) e.gout = 3'b110;
            else if (fn == 6'b100100) e.gout = 3'b000;
            else if (fn == 6'b100101) e.gout = 3'b001;
            else if (fn == 6'b100111) e.gout = 3'b100;
            else if (fn == 6'b101010) e.gout = 3'b111;
        end
        e.ovf    = 1'b0;
        e.result = 32'd0;
        if (e.gout == 3'b010) begin
            wide     = sx + sy;
            e.result = 32'(wide);
            e.ovf    = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
        end else if (e.gout == 3'b110) begin
            wide     = sx - sy;
            e.result = 32'(wide);
            e.ovf    = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
        end else if (e.gout == 3'b000) e.result = x & y;
        else if (e.gout == 3'b001) e.result = x | y;
        else if (e.gout == 3'b100) e.result = ~(x | y);
        else if (e.gout == 3'b111) e.result = (sx < sy) ? 32'd1 : 32'd0;
        e.zero         = (e.result == 32'd0);
        e.pcPlus4      = 32'(longint'(pcv) + 64'd4);
        e.branchTarget = 32'(longint'(pcv) + 64'd4 + longint'(imm) * 64'd4);
        return e;
    endfunction

    // Flag model: reset clears it at once; otherwise the flags of the
    // operation on the inputs are taken at each rising edge with flagWe set.
    always @(posedge clk or negedge rstN) begin
        expT e;
        if (!rstN) begin
            modelN <= 1'b0;
            modelZ <= 1'b0;
            modelV <= 1'b0;
        end else if (flagWe) begin
            e = modelCompute(aluop, funct, opA, opB, pc, immSext);
            modelN <= e.result[31];
            modelZ <= e.zero;
            modelV <= e.ovf;
        end
    end

    task automatic checkValue(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (aluop=%b funct=%b a=0x%08h b=0x%08h)",
                     name, actual, expected, aluop, funct, opA, opB);
        end
    endtask

    task automatic checkFlags();
        checkValue("flag_n", {31'd0, flagN}, {31'd0, modelN});
        checkValue("flag_z", {31'd0, flagZ}, {31'd0, modelZ});
        checkValue("flag_v", {31'd0, flagV}, {31'd0, modelV});
    endtask

    task automatic checkOutput(input expT e);
        checkValue("gout", {29'd0, gout}, {29'd0, e.gout});
        checkValue("result", result, e.result);
        checkValue("zero", {31'd0, zero}, {31'd0, e.zero});
        checkValue("pc_plus4", pcPlus4, e.pcPlus4);
        checkValue("branch_target", branchTarget, e.branchTarget);
        checkFlags();
    endtask

    // Monitor: one scoreboard entry is consumed per falling edge.
    initial begin
        expT e;
        forever begin
            @(negedge clk);
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput(e);
            end
        end
    end

    task automatic applyStimulus(input logic [1:0] op, input logic [5:0] fn,
                                 input logic [31:0] x, input logic [31:0] y,
                                 input logic [31:0] pcv, input logic [31:0] imm,
                                 input logic we);
        @(posedge clk);
        #1;
        aluop   = op;
        funct   = fn;
        opA     = x;
        opB     = y;
        pc      = pcv;
        immSext = imm;
        flagWe  = we;
        expQ.push_back(modelCompute(op, fn, x, y, pcv, imm));
    endtask

    function automatic logic [31:0] pickOperand();
        logic [31:0] specials [5];
        specials[0] = 32'h0000_0000;
        specials[1] = 32'h0000_0001;
        specials[2] = 32'h7FFF_FFFF;
        specials[3] = 32'h8000_0000;
        specials[4] = 32'hFFFF_FFFF;
        if ($urandom_range(0, 3) == 0) return specials[$urandom_range(0, 4)];
        return $urandom;
    endfunction

    // Main stimulus sequence
    initial begin
        logic [5:0]  functs [6];
        logic [5:0]  fn;
        logic [31:0] x;
        logic [31:0] y;
        functs[0] = 6'b100000;
        functs[1] = 6'b100010;
        functs[2] = 6'b100100;
        functs[3] = 6'b100101;
        functs[4] = 6'b100111;
        functs[5] = 6'b101010;

        rstN    = 1'b0;
        aluop   = 2'b00;
        funct   = 6'd0;
        opA     = 32'd0;
        opB     = 32'd0;
        pc      = 32'd0;
        immSext = 32'd0;
        flagWe  = 1'b1;

        // Flags read zero in reset even with flagWe high across an edge
        #8;
        checkValue("reset_flag_n", {31'd0, flagN}, 32'd0);
        checkValue("reset_flag_z", {31'd0, flagZ}, 32'd0);
        checkValue("reset_flag_v", {31'd0, flagV}, 32'd0);
        @(negedge clk);
        #2;
        rstN = 1'b1;
        $display("[TB] reset released");

        // Directed cases
        applyStimulus(2'b10, 6'b100000, 32'd7, 32'd5, 32'h0, 32'h0, 1'b1);
        applyStimulus(2'b01, 6'b000000, 32'h1234, 32'h1234, 32'h0, 32'h0, 1'b1);
        applyStimulus(2'b10, 6'b101010, 32'h8000_0000, 32'h1, 32'h0, 32'h0, 1'b0);
        applyStimulus(2'b10, 6'b101010, 32'h1, 32'hFFFF_FFFF, 32'h0, 32'h0, 1'b0);
        applyStimulus(2'b10, 6'b100000, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h0, 32'h0, 1'b1);
        applyStimulus(2'b10, 6'b100111, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
        applyStimulus(2'b00, 6'b000000, 32'h0, 32'h0, 32'h10, 32'hFFFF_FFFE, 1'b0);
        applyStimulus(2'b00, 6'b000000, 32'h0, 32'h0, 32'hFFFF_FFFC, 32'h0, 1'b0);
        applyStimulus(2'b11, 6'b111111, 32'h8000_0000, 32'h8000_0000, 32'h4, 32'h7FFF_FFFF, 1'b0);

        // Drop reset mid-cycle while n and v are set
        @(negedge clk);
        #2;
        rstN = 1'b0;
        #1;
        checkValue("async_flag_n", {31'd0, flagN}, 32'd0);
        checkValue("async_flag_z", {31'd0, flagZ}, 32'd0);
        checkValue("async_flag_v", {31'd0, flagV}, 32'd0);
        applyStimulus(2'b10, 6'b100000, 32'h7FFF_FFFF, 32'h1, 32'h0, 32'h0, 1'b1);
        applyStimulus(2'b10, 6'b100000, 32'h8000_0000, 32'h8000_0000, 32'h0, 32'h0, 1'b1);
        applyStimulus(2'b10, 6'b100000, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        #2;
        rstN = 1'b1;
        applyStimulus(2'b10, 6'b100000, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0, 1'b0);
        applyStimulus(2'b10, 6'b100000, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0, 1'b0);
        applyStimulus(2'b10, 6'b100010, 32'h8000_0000, 32'h1, 32'h0, 32'h0, 1'b1);
        applyStimulus(2'b00, 6'b000000, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);

        // Randomised operations
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) != 0) fn = functs[$urandom_range(0, 5)];
            else fn = 6'($urandom);
            x = pickOperand();
            y = ($urandom_range(0, 7) == 0) ? x : pickOperand();
            applyStimulus(2'($urandom_range(0, 3)), fn, x, y, $urandom, pickOperand(),
                          1'($urandom_range(0, 1)));
        end

        // Let the monitor drain the scoreboard, bounded
        for (int i = 0; i < 10 && expQ.size() != 0; i++) @(negedge clk);
        #1;
        if (expQ.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain: %0d entries left, expected 0", expQ.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
